// File: rtl/y86_status_pkg.sv
// Shared Y86 status codes, terminal/error classification and the run FSM state type
// used by the run supervisor and its per-core trackers.
package y86_status_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  // Codes 0 and 1 keep a core running; HLT and everything above it stops the core.
  function automatic logic is_terminal(input logic [2:0] stat);
    return (stat >= STAT_HLT);
  endfunction

  function automatic logic is_error(input logic [2:0] stat);
    return is_terminal(stat) && (stat != STAT_HLT);
  endfunction

endpackage

// File: rtl/core_stop_tracker.sv
// Per-core latch of the first terminal status and the cycle at which it appeared;
// also exposes the post-update halted/error view used by the run exit logic.
module core_stop_tracker #(
  parameter int CYCLE_W = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_sample_en,
  input  logic [2:0]         i_status,
  input  logic [CYCLE_W-1:0] i_cycle_count,
  output logic               o_halted,
  output logic [2:0]         o_final_status,
  output logic [CYCLE_W-1:0] o_stop_cycle,
  output logic               o_halted_next,
  output logic               o_error_next
);
  import y86_status_pkg::*;

  logic               r_halted;
  logic [2:0]         r_final_status;
  logic [CYCLE_W-1:0] r_stop_cycle;
  logic               w_capture;

  assign w_capture = i_sample_en && !r_halted && is_terminal(i_status);

  // Only the first terminal status is kept; later changes on the channel are ignored.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_halted       <= 1'b0;
      r_final_status <= '0;
      r_stop_cycle   <= '0;
    end else if (w_capture) begin
      r_halted       <= 1'b1;
      r_final_status <= i_status;
      r_stop_cycle   <= i_cycle_count;
    end
  end

  assign o_halted       = r_halted;
  assign o_final_status = r_final_status;
  assign o_stop_cycle   = r_stop_cycle;
  assign o_halted_next  = r_halted | w_capture;
  assign o_error_next   = r_halted ? is_error(r_final_status)
                                   : (w_capture && is_error(i_status));

endmodule

// File: rtl/run_status_monitor.sv
// Run supervisor for one or more Y86 cores: counts run cycles, ends the run on
// all-halted, first error (optional) or watchdog, and reports pass/finish.
module run_status_monitor #(
  parameter int NUM_CORES      = 1,
  parameter int CYCLE_W        = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ABORT_ON_ERROR = 0
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [NUM_CORES*3-1:0]         i_status,
  output logic                           o_run_active,
  output logic [NUM_CORES-1:0]           o_halted_vec,
  output logic [NUM_CORES*3-1:0]         o_final_status,
  output logic [NUM_CORES*CYCLE_W-1:0]   o_stop_cycle,
  output logic [CYCLE_W-1:0]             o_cycle_count,
  output logic                           o_finish,
  output logic                           o_timed_out,
  output logic                           o_pass
);
  import y86_status_pkg::*;

  localparam logic [CYCLE_W-1:0] LP_LAST_CYCLE = CYCLE_W'(TIMEOUT_CYCLES - 1);

  run_state_t           r_state;
  run_state_t           w_state_next;
  logic [CYCLE_W-1:0]   r_cycle_count;
  logic                 r_finish;
  logic                 r_timed_out;
  logic                 w_clear;
  logic                 w_sample;
  logic                 w_timeout_hit;
  logic                 w_all_hlt;
  logic [NUM_CORES-1:0] w_halted_next;
  logic [NUM_CORES-1:0] w_error_next;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    core_stop_tracker #(.CYCLE_W(CYCLE_W)) u_tracker (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_clear       (w_clear),
      .i_sample_en   (w_sample),
      .i_status      (i_status[3*g +: 3]),
      .i_cycle_count (r_cycle_count),
      .o_halted      (o_halted_vec[g]),
      .o_final_status(o_final_status[3*g +: 3]),
      .o_stop_cycle  (o_stop_cycle[CYCLE_W*g +: CYCLE_W]),
      .o_halted_next (w_halted_next[g]),
      .o_error_next  (w_error_next[g])
    );
  end

  // Exit priority: all halted, then abort-on-error, then watchdog.
  always_comb begin
    w_state_next  = r_state;
    w_clear       = 1'b0;
    w_sample      = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_next = RUN;
          w_clear      = 1'b1;
        end
      end
      RUN: begin
        w_sample = 1'b1;
        if (&w_halted_next) begin
          w_state_next = DONE;
        end else if ((ABORT_ON_ERROR != 0) && (|w_error_next)) begin
          w_state_next = DONE;
        end else if (r_cycle_count == LP_LAST_CYCLE) begin
          w_state_next  = DONE;
          w_timeout_hit = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cycle_count <= '0;
      r_finish      <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_finish <= (r_state == RUN) && (w_state_next == DONE);
      if (w_clear) begin
        r_cycle_count <= '0;
        r_timed_out   <= 1'b0;
      end else if (w_sample) begin
        r_cycle_count <= r_cycle_count + CYCLE_W'(1);
        if (w_timeout_hit) r_timed_out <= 1'b1;
      end
    end
  end

  always_comb begin
    w_all_hlt = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!o_halted_vec[i] || (o_final_status[3*i +: 3] != STAT_HLT)) w_all_hlt = 1'b0;
    end
  end

  assign o_run_active  = (r_state == RUN);
  assign o_cycle_count = r_cycle_count;
  assign o_finish      = r_finish;
  assign o_timed_out   = r_timed_out;
  assign o_pass        = (r_state == DONE) && !r_timed_out && w_all_hlt;

endmodule

// File: tb/tb_run_status_monitor.sv
// Self-checking bench: two monitors (abort off / abort on) share stimulus and are
// compared every cycle against a behavioural run model, plus table and directed sequences.
module tb_run_status_monitor;

  localparam int TMO = 10;

  logic        clock;
  logic        reset;
  logic        start;
  logic [5:0]  status;

  logic        aRun, bRun, aFinish, bFinish, aTo, bTo, aPass, bPass;
  logic [1:0]  aHalt, bHalt;
  logic [5:0]  aFinal, bFinal;
  logic [31:0] aStop, bStop;
  logic [15:0] aCount, bCount;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state per instance: 0 idle, 1 running, 2 done.
  int mState[2];
  int mCount[2];
  int mHalt[2][2];
  int mFinal[2][2];
  int mStop[2][2];
  int mTo[2];
  int mFin[2];

  typedef struct {
    bit          rst;
    bit          st;
    logic [5:0]  stat;
    bit          expRun;
    logic [1:0]  expHalt;
    bit          expFinish;
    bit          expPass;
    bit          expTo;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs[10];

  run_status_monitor #(.NUM_CORES(2), .CYCLE_W(16), .TIMEOUT_CYCLES(TMO), .ABORT_ON_ERROR(0)) dutA (
    .i_clock(clock), .i_reset(reset), .i_start(start), .i_status(status),
    .o_run_active(aRun), .o_halted_vec(aHalt), .o_final_status(aFinal), .o_stop_cycle(aStop),
    .o_cycle_count(aCount), .o_finish(aFinish), .o_timed_out(aTo), .o_pass(aPass)
  );

  run_status_monitor #(.NUM_CORES(2), .CYCLE_W(16), .TIMEOUT_CYCLES(TMO), .ABORT_ON_ERROR(1)) dutB (
    .i_clock(clock), .i_reset(reset), .i_start(start), .i_status(status),
    .o_run_active(bRun), .o_halted_vec(bHalt), .o_final_status(bFinal), .o_stop_cycle(bStop),
    .o_cycle_count(bCount), .o_finish(bFinish), .o_timed_out(bTo), .o_pass(bPass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear(input int m);
    mCount[m] = 0;
    mTo[m]    = 0;
    for (int i = 0; i < 2; i++) begin
      mHalt[m][i]  = 0;
      mFinal[m][i] = 0;
      mStop[m][i]  = 0;
    end
  endtask

  task automatic modelStep(input int m, input int abortOn, input bit rst, input bit st, input logic [5:0] stat);
    int s[2];
    int allH;
    int anyErr;
    s[0] = int'(stat[2:0]);
    s[1] = int'(stat[5:3]);
    mFin[m] = 0;
    if (rst) begin
      mState[m] = 0;
      modelClear(m);
    end else if (mState[m] != 1) begin
      if (st) begin
        mState[m] = 1;
        modelClear(m);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mHalt[m][i] == 0 && s[i] >= 2) begin
          mHalt[m][i]  = 1;
          mFinal[m][i] = s[i];
          mStop[m][i]  = mCount[m];
        end
      end
      mCount[m]++;
      allH   = 1;
      anyErr = 0;
      for (int i = 0; i < 2; i++) begin
        if (mHalt[m][i] == 0) allH = 0;
        if (mHalt[m][i] != 0 && mFinal[m][i] != 2) anyErr = 1;
      end
      if (allH != 0) mState[m] = 2;
      else if (abortOn != 0 && anyErr != 0) mState[m] = 2;
      else if (mCount[m] == TMO) begin
        mState[m] = 2;
        mTo[m]    = 1;
      end
      if (mState[m] == 2) mFin[m] = 1;
    end
  endtask

  task automatic compareDut(input string tag, input int m, input logic run, input logic [1:0] halt,
                            input logic [5:0] fin, input logic [31:0] stop, input logic [15:0] cnt,
                            input logic fns, input logic to, input logic ps);
    logic [1:0]  eHalt;
    logic [5:0]  eFin;
    logic [31:0] eStop;
    logic        ePass;
    eHalt = {mHalt[m][1] != 0, mHalt[m][0] != 0};
    eFin  = {3'(mFinal[m][1]), 3'(mFinal[m][0])};
    eStop = {16'(mStop[m][1]), 16'(mStop[m][0])};
    ePass = (mState[m] == 2) && (mTo[m] == 0) && (mHalt[m][0] != 0) && (mHalt[m][1] != 0) &&
            (mFinal[m][0] == 2) && (mFinal[m][1] == 2);
    checkOutput({tag, ".run_active"},   64'(run),  64'(mState[m] == 1));
    checkOutput({tag, ".halted_vec"},   64'(halt), 64'(eHalt));
    checkOutput({tag, ".final_status"}, 64'(fin),  64'(eFin));
    checkOutput({tag, ".stop_cycle"},   64'(stop), 64'(eStop));
    checkOutput({tag, ".cycle_count"},  64'(cnt),  64'(16'(mCount[m])));
    checkOutput({tag, ".finish"},       64'(fns),  64'(mFin[m] != 0));
    checkOutput({tag, ".timed_out"},    64'(to),   64'(mTo[m] != 0));
    checkOutput({tag, ".pass"},         64'(ps),   64'(ePass));
  endtask

  // One clock: drive inputs, let the edge happen, sample #1 later against the model.
  task automatic applyStimulus(input bit rst, input bit st, input logic [5:0] stat);
    reset  = rst;
    start  = st;
    status = stat;
    @(posedge clock);
    #1;
    modelStep(0, 0, rst, st, stat);
    modelStep(1, 1, rst, st, stat);
    compareDut("A", 0, aRun, aHalt, aFinal, aStop, aCount, aFinish, aTo, aPass);
    compareDut("B", 1, bRun, bHalt, bFinal, bStop, bCount, bFinish, bTo, bPass);
  endtask

  function automatic logic [2:0] randStat();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return 3'd1;
    if (r < 85) return 3'd0;
    if (r < 93) return 3'd2;
    return 3'($urandom_range(3, 7));
  endfunction

  localparam logic [5:0] AOK2 = 6'b001_001;
  localparam logic [5:0] HLT2 = 6'b010_010;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    status = AOK2;
    for (int m = 0; m < 2; m++) begin
      mState[m] = 0;
      mFin[m]   = 0;
      modelClear(m);
    end

    vecs[0] = '{1'b1, 1'b0, 6'b001_001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 6'b001_010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 6'b001_001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[3] = '{1'b0, 1'b0, 6'b001_010, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[4] = '{1'b0, 1'b0, 6'b001_001, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[5] = '{1'b0, 1'b0, 6'b011_001, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 16'd4};
    vecs[6] = '{1'b0, 1'b0, 6'b001_001, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[7] = '{1'b0, 1'b1, 6'b010_010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[8] = '{1'b0, 1'b0, 6'b010_010, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[9] = '{1'b0, 1'b0, 6'b001_001, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'd1};

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].st, vecs[v].stat);
      checkOutput($sformatf("vec%0d.run_active", v), 64'(aRun),    64'(vecs[v].expRun));
      checkOutput($sformatf("vec%0d.halted_vec", v), 64'(aHalt),   64'(vecs[v].expHalt));
      checkOutput($sformatf("vec%0d.finish", v),     64'(aFinish), 64'(vecs[v].expFinish));
      checkOutput($sformatf("vec%0d.pass", v),       64'(aPass),   64'(vecs[v].expPass));
      checkOutput($sformatf("vec%0d.timed_out", v),  64'(aTo),     64'(vecs[v].expTo));
      checkOutput($sformatf("vec%0d.cycle_count", v),64'(aCount),  64'(vecs[v].expCount));
    end
    checkOutput("vec.final_status", 64'(aFinal), 64'(6'b010_010));

    // Watchdog: AOK held for the whole budget.
    applyStimulus(1'b1, 1'b0, AOK2);
    applyStimulus(1'b0, 1'b1, AOK2);
    repeat (TMO - 1) applyStimulus(1'b0, 1'b0, AOK2);
    checkOutput("tmo.still_running", 64'(aRun), 64'd1);
    applyStimulus(1'b0, 1'b0, AOK2);
    checkOutput("tmo.run_active",  64'(aRun),    64'd0);
    checkOutput("tmo.timed_out",   64'(aTo),     64'd1);
    checkOutput("tmo.cycle_count", 64'(aCount),  64'(TMO));
    checkOutput("tmo.halted_vec",  64'(aHalt),   64'd0);
    checkOutput("tmo.pass",        64'(aPass),   64'd0);
    checkOutput("tmo.finish",      64'(aFinish), 64'd1);

    // Halt on the watchdog edge wins, then restart from DONE.
    applyStimulus(1'b1, 1'b0, AOK2);
    applyStimulus(1'b0, 1'b1, AOK2);
    repeat (TMO - 1) applyStimulus(1'b0, 1'b0, AOK2);
    applyStimulus(1'b0, 1'b0, HLT2);
    checkOutput("edge.timed_out",   64'(aTo),          64'd0);
    checkOutput("edge.pass",        64'(aPass),        64'd1);
    checkOutput("edge.stop_cycle0", 64'(aStop[15:0]),  64'd9);
    checkOutput("edge.cycle_count", 64'(aCount),       64'(TMO));
    applyStimulus(1'b0, 1'b1, HLT2);
    checkOutput("restart.run_active",  64'(aRun),   64'd1);
    checkOutput("restart.cycle_count", 64'(aCount), 64'd0);
    applyStimulus(1'b0, 1'b0, HLT2);
    checkOutput("restart.stop_cycle0", 64'(aStop[15:0]), 64'd0);
    checkOutput("restart.pass",        64'(aPass),       64'd1);

    // Abort-on-error instance stops on core1 INS while core0 is still running.
    applyStimulus(1'b1, 1'b0, AOK2);
    applyStimulus(1'b0, 1'b1, AOK2);
    repeat (2) applyStimulus(1'b0, 1'b0, AOK2);
    applyStimulus(1'b0, 1'b0, 6'b100_001);
    checkOutput("abort.run_active",  64'(bRun),    64'd0);
    checkOutput("abort.halted_vec",  64'(bHalt),   64'(2'b10));
    checkOutput("abort.pass",        64'(bPass),   64'd0);
    checkOutput("abort.timed_out",   64'(bTo),     64'd0);
    checkOutput("abort.cycle_count", 64'(bCount),  64'd3);
    checkOutput("abort.finish",      64'(bFinish), 64'd1);
    checkOutput("abort.noabortA",    64'(aRun),    64'd1);

    // Reset with start high mid-run, then a fresh start.
    applyStimulus(1'b1, 1'b0, AOK2);
    applyStimulus(1'b0, 1'b1, AOK2);
    repeat (4) applyStimulus(1'b0, 1'b0, AOK2);
    applyStimulus(1'b1, 1'b1, 6'b010_001);
    checkOutput("rst.run_active",   64'(aRun),   64'd0);
    checkOutput("rst.cycle_count",  64'(aCount), 64'd0);
    checkOutput("rst.halted_vec",   64'(aHalt),  64'd0);
    checkOutput("rst.final_status", 64'(aFinal), 64'd0);
    checkOutput("rst.stop_cycle",   64'(aStop),  64'd0);
    applyStimulus(1'b0, 1'b1, AOK2);
    checkOutput("rst.fresh_run",    64'(aRun),   64'd1);
    applyStimulus(1'b0, 1'b0, AOK2);
    checkOutput("rst.fresh_count",  64'(aCount), 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25, {randStat(), randStat()});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
